// File: rtl/quicksort_ctrl.sv
// Purpose: sequences the partition engine over a stack of {lo,hi} ranges to sort an N-entry array.
// Latency: start -> busy next cycle, first part_init two cycles after start; done one cycle after the last pop or an abort.
// Backpressure: each request holds part_init until part_complete is seen low, then waits for part_complete high.
module quicksort_ctrl #(
    parameter int N  = 8,
    parameter int SD = N
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] part_i,
    output logic [31:0] part_j,
    output logic [31:0] part_loc,
    output logic        part_init,
    input  logic        part_complete,
    input  logic [31:0] part_pivot
);

    localparam int SPW   = $clog2(SD + 1);
    localparam int DEPTH = 1 << SPW;
    localparam logic [SPW-1:0] SP_ONE  = 1;
    localparam logic [SPW:0]   SD_W    = (SPW + 1)'(SD);
    localparam logic [31:0]    HI_INIT = 32'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_ISSUE,
        S_WAIT,
        S_PUSH,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [SPW-1:0] sp;
    logic [63:0]    stack [DEPTH];
    logic [31:0]    lo;
    logic [31:0]    hi;
    logic [31:0]    piv;

    logic        accept;
    logic        pop_en;
    logic        cap_en;
    logic        push_en;
    logic        set_err;

    // Top-of-stack entry; only meaningful when sp is non-zero.
    logic [63:0] top_ent;
    logic [31:0] top_lo;
    logic [31:0] top_hi;
    assign top_ent = stack[sp - SP_ONE];
    assign top_lo  = top_ent[63:32];
    assign top_hi  = top_ent[31:0];

    // Sub-range guards are done in 33 bits so p+1 and lo+1 cannot wrap.
    logic [32:0]    piv_inc;
    logic [32:0]    lo_inc;
    logic           need_r;
    logic           need_l;
    logic [SPW:0]   sp_sum;
    logic           overflow;
    logic [SPW-1:0] sp_left;
    logic           piv_bad;

    assign piv_inc  = {1'b0, piv} + 33'd1;
    assign lo_inc   = {1'b0, lo} + 33'd1;
    assign need_r   = piv_inc < {1'b0, hi};
    assign need_l   = {1'b0, piv} > lo_inc;
    assign sp_sum   = {1'b0, sp} + {{SPW{1'b0}}, need_r} + {{SPW{1'b0}}, need_l};
    assign overflow = sp_sum > SD_W;
    assign sp_left  = need_r ? (sp + SP_ONE) : sp;
    assign piv_bad  = (part_pivot < lo) || (part_pivot > hi);

    // Request outputs come straight from the registered current range.
    assign busy      = (state == S_POP) || (state == S_ISSUE) || (state == S_WAIT) || (state == S_PUSH);
    assign done      = (state == S_DONE);
    assign part_init = (state == S_ISSUE);
    assign part_i    = lo;
    assign part_j    = hi;
    assign part_loc  = lo;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle datapath enables.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        pop_en    = 1'b0;
        cap_en    = 1'b0;
        push_en   = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                if (sp == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    pop_en    = 1'b1;
                    state_nxt = (top_lo < top_hi) ? S_ISSUE : S_POP;
                end
            end
            S_ISSUE: begin
                // A completion still high here belongs to the previous range.
                if (!part_complete) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (part_complete) begin
                    if (piv_bad) begin
                        set_err   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        cap_en    = 1'b1;
                        state_nxt = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                if (overflow) begin
                    set_err   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    push_en   = 1'b1;
                    state_nxt = S_POP;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Stack pointer, current range, captured pivot and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp  <= '0;
            lo  <= '0;
            hi  <= '0;
            piv <= '0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                sp  <= SP_ONE;
                err <= 1'b0;
            end
            if (pop_en) begin
                lo <= top_lo;
                hi <= top_hi;
                sp <= sp - SP_ONE;
            end
            if (cap_en) begin
                piv <= part_pivot;
            end
            if (push_en) begin
                sp <= sp_sum[SPW-1:0];
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    // Range storage; right range goes below left so the left range pops first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                stack[0] <= {32'd0, HI_INIT};
            end
            if (push_en) begin
                if (need_r) begin
                    stack[sp] <= {piv + 32'd1, hi};
                end
                if (need_l) begin
                    stack[sp_left] <= {lo, piv - 32'd1};
                end
            end
        end
    end

endmodule
